// File: rtl/if_id_buffer.sv
// Two-entry IF/ID buffer: captures fetched {pc, inst} pairs and hands them to decode with fields pre-split.
// Latency 1 cycle from push to id_* visibility, with no bypass path.
// Backpressure: if_ready drops when both entries are full and is decoded from registers only.
module if_id_buffer #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [INST_W-1:0] id_inst,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_funct,
    output logic [15:0]       id_imm,
    output logic [25:0]       id_target,
    output logic [1:0]        occupancy,
    output logic [7:0]        flush_drops
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t     head;
    entry_t     tail;
    entry_t     in_entry;
    logic       push;
    logic       pop;
    logic [8:0] drops_sum;
    logic [7:0] drops_nxt;

    assign if_ready = (occupancy != 2'd2);
    assign id_valid = (occupancy != 2'd0);
    assign push     = if_valid && if_ready;
    assign pop      = id_valid && id_ready;

    assign in_entry.pc   = if_pc;
    assign in_entry.inst = if_inst;

    assign drops_sum = {1'b0, flush_drops} + {7'd0, occupancy};
    assign drops_nxt = drops_sum[8] ? 8'hFF : drops_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy   <= 2'd0;
            head        <= '0;
            tail        <= '0;
            flush_drops <= 8'd0;
        end else if (flush) begin
            // Flush wins over any same-cycle push/pop; the pushed pair is simply lost.
            occupancy   <= 2'd0;
            flush_drops <= drops_nxt;
        end else begin
            case (occupancy)
                2'd0: begin
                    if (push) begin
                        head      <= in_entry;
                        occupancy <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_entry;
                    end else if (push) begin
                        tail      <= in_entry;
                        occupancy <= 2'd2;
                    end else if (pop) begin
                        occupancy <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head      <= tail;
                        occupancy <= 2'd1;
                    end
                end
                default: occupancy <= 2'd0;
            endcase
        end
    end

    // Head pc is left untouched on the final pop, so id_pc keeps its last value while empty.
    assign id_pc       = head.pc;
    assign id_pc_plus4 = head.pc + ADDR_W'(4);
    assign id_inst     = id_valid ? head.inst : NOP_INST;

    assign id_opcode = id_inst[31:26];
    assign id_rs     = id_inst[25:21];
    assign id_rt     = id_inst[20:16];
    assign id_rd     = id_inst[15:11];
    assign id_shamt  = id_inst[10:6];
    assign id_funct  = id_inst[5:0];
    assign id_imm    = id_inst[15:0];
    assign id_target = id_inst[25:0];

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed testbench for if_id_buffer: handshake, ordering, flush, wrap and saturation.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;
    logic [25:0] id_target;
    logic [1:0]  occupancy;
    logic [7:0]  flush_drops;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.ADDR_W(32), .INST_W(32), .NOP_INST(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .id_inst(id_inst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm(id_imm), .id_target(id_target),
        .occupancy(occupancy), .flush_drops(flush_drops)
    );

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return 32'h2000_0000 | pc;
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got %h want 0", id_valid); end
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got %h want 1", if_ready); end
        n_checks++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
        n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
        n_checks++; if (id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4 got %h want 4", id_pc_plus4); end
        n_checks++; if (occupancy !== 2'd0 || flush_drops !== 8'd0) begin n_fail++; $display("FAIL reset_counts got occ=%0d drops=%0d want 0/0", occupancy, flush_drops); end
    endtask

    task automatic test_single();
        if_valid = 1'b1; if_pc = 32'h0; if_inst = 32'h8C08_0004; id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %h want 1", id_valid); end
        n_checks++; if (id_opcode !== 6'h23 || id_rs !== 5'd0 || id_rt !== 5'd8) begin n_fail++; $display("FAIL single_fields got op=%h rs=%0d rt=%0d want 23/0/8", id_opcode, id_rs, id_rt); end
        n_checks++; if (id_imm !== 16'h0004 || id_target !== 26'h008_0004) begin n_fail++; $display("FAIL single_imm got imm=%h tgt=%h want 0004/0080004", id_imm, id_target); end
        n_checks++; if (id_rd !== 5'd0 || id_shamt !== 5'd0 || id_funct !== 6'h04) begin n_fail++; $display("FAIL single_rfields got rd=%0d sh=%0d fn=%h want 0/0/04", id_rd, id_shamt, id_funct); end
        n_checks++; if (id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL single_pc_plus4 got %h want 4", id_pc_plus4); end
        tick();
        n_checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL single_drain got v=%h inst=%h want 0/0", id_valid, id_inst); end
    endtask

    task automatic test_back_to_back();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h0; if_inst = mk_inst(32'h0);
        tick();
        n_checks++; if (occupancy !== 2'd1 || if_ready !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL b2b_first got occ=%0d rdy=%h pc=%h want 1/1/0", occupancy, if_ready, id_pc); end
        if_pc = 32'h4; if_inst = mk_inst(32'h4);
        tick();
        n_checks++; if (occupancy !== 2'd2 || if_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got occ=%0d rdy=%h want 2/0", occupancy, if_ready); end
        if_pc = 32'h8; if_inst = mk_inst(32'h8);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (occupancy !== 2'd2 || id_pc !== 32'h0 || id_inst !== mk_inst(32'h0)) begin n_fail++; $display("FAIL b2b_hold got occ=%0d pc=%h inst=%h want 2/0/%h", occupancy, id_pc, id_inst, mk_inst(32'h0)); end
        end
        id_ready = 1'b1;
        tick();
        n_checks++; if (id_pc !== 32'h4 || id_inst !== mk_inst(32'h4) || occupancy !== 2'd1 || if_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second got pc=%h inst=%h occ=%0d rdy=%h want 4/%h/1/1", id_pc, id_inst, occupancy, if_ready, mk_inst(32'h4)); end
        tick();
        if_valid = 1'b0;
        n_checks++; if (id_pc !== 32'h8 || id_inst !== mk_inst(32'h8) || occupancy !== 2'd1) begin n_fail++; $display("FAIL b2b_third got pc=%h inst=%h occ=%0d want 8/%h/1", id_pc, id_inst, occupancy, mk_inst(32'h8)); end
        tick();
        n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h8) begin n_fail++; $display("FAIL b2b_empty got v=%h pc=%h want 0/8", id_valid, id_pc); end
    endtask

    task automatic test_stream();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h100; if_inst = mk_inst(32'h100);
        tick();
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_pc = 32'h104 + 32'(4 * i); if_inst = mk_inst(if_pc);
            tick();
            n_checks++; if (occupancy !== 2'd1 || id_valid !== 1'b1 || id_pc !== 32'h104 + 32'(4 * i)) begin n_fail++; $display("FAIL stream_%0d got occ=%0d v=%h pc=%h want 1/1/%h", i, occupancy, id_valid, id_pc, 32'h104 + 32'(4 * i)); end
        end
        if_valid = 1'b0;
        tick();
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h200; if_inst = mk_inst(32'h200);
        tick();
        if_pc = 32'h204; if_inst = mk_inst(32'h204);
        tick();
        flush = 1'b1; id_ready = 1'b1; if_pc = 32'hDEAD_0000; if_inst = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        n_checks++; if (occupancy !== 2'd0 || id_valid !== 1'b0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL flush_clear got occ=%0d v=%h inst=%h want 0/0/0", occupancy, id_valid, id_inst); end
        n_checks++; if (flush_drops !== 8'd2) begin n_fail++; $display("FAIL flush_drops got %0d want 2", flush_drops); end
        tick();
        n_checks++; if (id_valid !== 1'b0 || id_pc === 32'hDEAD_0000) begin n_fail++; $display("FAIL flush_no_leak got v=%h pc=%h want 0/not dead0000", id_valid, id_pc); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (flush_drops !== 8'd2 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_empty got drops=%0d occ=%0d want 2/0", flush_drops, occupancy); end
    endtask

    task automatic test_wrap();
        id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'hFFFF_FFFC; if_inst = 32'h0800_0001;
        tick();
        if_valid = 1'b0;
        n_checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap got pc=%h plus4=%h want fffffffc/0", id_pc, id_pc_plus4); end
        n_checks++; if (id_target !== 26'h000_0001 || id_opcode !== 6'h02) begin n_fail++; $display("FAIL wrap_jfields got op=%h tgt=%h want 02/0000001", id_opcode, id_target); end
        tick();
    endtask

    task automatic test_saturate_and_reset();
        int exp_drops;
        exp_drops = 2;
        for (int i = 0; i < 130; i++) begin
            id_ready = 1'b0; if_valid = 1'b1; if_pc = 32'(i * 8); if_inst = mk_inst(if_pc);
            tick(); tick();
            flush = 1'b1; if_valid = 1'b0;
            tick();
            flush = 1'b0;
            exp_drops = (exp_drops + 2 > 255) ? 255 : exp_drops + 2;
            n_checks++; if (flush_drops !== 8'(exp_drops)) begin n_fail++; $display("FAIL sat_%0d got %0d want %0d", i, flush_drops, exp_drops); end
        end
        id_ready = 1'b0; if_valid = 1'b1; if_pc = 32'h300; if_inst = mk_inst(32'h300);
        tick();
        if_valid = 1'b0;
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL prerst_occ got %0d want 1", occupancy); end
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        n_checks++; if (occupancy !== 2'd0 || flush_drops !== 8'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL rst_state got occ=%0d drops=%0d v=%h rdy=%h want 0/0/0/1", occupancy, flush_drops, id_valid, if_ready); end
        n_checks++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || id_inst !== 32'h0) begin n_fail++; $display("FAIL rst_outputs got pc=%h plus4=%h inst=%h want 0/4/0", id_pc, id_pc_plus4, id_inst); end
        id_ready = 1'b1;
        tick(); tick();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_emit got v=%h want 0", id_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_flush();
        test_wrap();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
